// File: rtl/spi_slave_rx_if.sv
// spi_slave_rx_if: bundle of the SPI slave receiver's serial lines and its
// parallel word interface.
//   slave  modport: the receiver's view (serial lines and tx_data in,
//                   miso and received-word signals out)
//   master modport: the SPI master / host view (the mirror image)
// Signals:
//   sclk_in, ss_in, mosi : serial lines from the master (asynchronous)
//   miso                 : serial data back to the master
//   tx_data              : word returned on miso, captured at frame start
//   rx_data, rx_valid    : last received word and its one-cycle strobe
//   rx_err               : one-cycle strobe for a frame that ended short
//   busy                 : receiver is inside a selected frame
`timescale 1ns/1ps

interface spi_slave_rx_if #(
    parameter int WIDTH = 16
);
    logic             sclk_in;
    logic             ss_in;
    logic             mosi;
    logic             miso;
    logic [WIDTH-1:0] tx_data;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             rx_err;
    logic             busy;

    modport slave (
        input  sclk_in, ss_in, mosi, tx_data,
        output miso, rx_data, rx_valid, rx_err, busy
    );

    modport master (
        output sclk_in, ss_in, mosi, tx_data,
        input  miso, rx_data, rx_valid, rx_err, busy
    );
endinterface

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: SPI slave receiver. Oversamples SCLK/SS/MOSI with clk,
// rebuilds MSB-first WIDTH-bit words and strobes rx_valid once per word.
// A frame that ends with a partial word strobes rx_err instead.
//
// Ports:
//   clk  : system clock, at least 4x the SCLK frequency
//   rst  : synchronous active-high reset
//   bus  : spi_slave_rx_if.slave (serial lines, tx_data, rx_data,
//          rx_valid, rx_err, busy, miso)
//
// Build option: define SPI_SLAVE_TX_EN to compile in the MISO return path.
// Without it, miso is held at 0 and tx_data is ignored.
//
// All edge detection works on synchronized copies, so every reaction is
// three clk edges after the edge that first samples the input change.
`timescale 1ns/1ps

module spi_slave_rx #(
    parameter int WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    spi_slave_rx_if.slave bus
);

    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_DESEL_WAIT = 2'd0,
        ST_IDLE       = 2'd1,
        ST_ACTIVE     = 2'd2
    } state_t;

    // Synchronizer and history flops
    logic sclk_m_r, sclk_s_r, sclk_h_r;
    logic ss_m_r,   ss_s_r,   ss_h_r;
    logic mosi_m_r, mosi_s_r;

    // Edge strobes derived from the synchronized lines
    logic sclk_rise_s, sclk_fall_s, ss_fall_s, ss_rise_s;

    // FSM and receive datapath
    state_t           state_r, state_nxt_s;
    logic [WIDTH-1:0] shift_r, shift_nxt_s;
    logic [CW-1:0]    cnt_r, cnt_nxt_s, cnt_inc_s;
    logic [WIDTH-1:0] rx_data_r, rx_data_nxt_s;
    logic             rx_valid_r, rx_valid_nxt_s;
    logic             rx_err_r, rx_err_nxt_s;
    logic             busy_r;
    logic             miso_r, miso_nxt_s;

    // Bring the asynchronous SPI lines into the clk domain. SS resets to the
    // "selected" level so a frame already running at reset is not mistaken
    // for a fresh select once reset releases.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_m_r <= 1'b0;
            sclk_s_r <= 1'b0;
            sclk_h_r <= 1'b0;
            ss_m_r   <= 1'b0;
            ss_s_r   <= 1'b0;
            ss_h_r   <= 1'b0;
            mosi_m_r <= 1'b0;
            mosi_s_r <= 1'b0;
        end else begin
            sclk_m_r <= bus.sclk_in;
            sclk_s_r <= sclk_m_r;
            sclk_h_r <= sclk_s_r;
            ss_m_r   <= bus.ss_in;
            ss_s_r   <= ss_m_r;
            ss_h_r   <= ss_s_r;
            mosi_m_r <= bus.mosi;
            mosi_s_r <= mosi_m_r;
        end
    end

    assign sclk_rise_s = sclk_s_r & ~sclk_h_r;
    assign sclk_fall_s = ~sclk_s_r & sclk_h_r;
    assign ss_fall_s   = ~ss_s_r & ss_h_r;
    assign ss_rise_s   = ss_s_r & ~ss_h_r;
    assign cnt_inc_s   = cnt_r + CNT_ONE;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_DESEL_WAIT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_DESEL_WAIT: begin
                if (ss_s_r) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DESEL_WAIT;
                end
            end
            ST_IDLE: begin
                if (ss_fall_s) begin
                    state_nxt_s = ST_ACTIVE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (ss_rise_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ACTIVE;
                end
            end
            default: begin
                state_nxt_s = ST_DESEL_WAIT;
            end
        endcase
    end

    // FSM output decode: next values of the receive datapath and strobes
    always_comb begin
        shift_nxt_s    = shift_r;
        cnt_nxt_s      = cnt_r;
        rx_data_nxt_s  = rx_data_r;
        rx_valid_nxt_s = 1'b0;
        rx_err_nxt_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ss_fall_s) begin
                    shift_nxt_s = {WIDTH{1'b0}};
                    cnt_nxt_s   = {CW{1'b0}};
                end else begin
                    shift_nxt_s = shift_r;
                    cnt_nxt_s   = cnt_r;
                end
            end
            ST_ACTIVE: begin
                if (sclk_rise_s) begin
                    shift_nxt_s = {shift_r[WIDTH-2:0], mosi_s_r};
                    if (cnt_inc_s == CNT_LAST) begin
                        rx_data_nxt_s  = {shift_r[WIDTH-2:0], mosi_s_r};
                        rx_valid_nxt_s = 1'b1;
                        cnt_nxt_s      = {CW{1'b0}};
                    end else begin
                        cnt_nxt_s = cnt_inc_s;
                    end
                end else begin
                    shift_nxt_s = shift_r;
                end
                // Deselect is judged on the count after this cycle's bit, so a
                // bit that completes the word in the same cycle is not an error.
                if (ss_rise_s && (cnt_nxt_s != {CW{1'b0}})) begin
                    rx_err_nxt_s = 1'b1;
                end else begin
                    rx_err_nxt_s = 1'b0;
                end
            end
            default: begin
                rx_valid_nxt_s = 1'b0;
                rx_err_nxt_s   = 1'b0;
            end
        endcase
    end

`ifdef SPI_SLAVE_TX_EN
    logic [WIDTH-1:0] tx_shift_r, tx_shift_nxt_s;
    logic [CW-1:0]    tx_cnt_r, tx_cnt_nxt_s, tx_cnt_inc_s;

    assign tx_cnt_inc_s = tx_cnt_r + CNT_ONE;

    // MISO shifter next values: load at select, shift on SCLK fall, reload per word
    always_comb begin
        tx_shift_nxt_s = tx_shift_r;
        tx_cnt_nxt_s   = tx_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (ss_fall_s) begin
                    tx_shift_nxt_s = bus.tx_data;
                    tx_cnt_nxt_s   = {CW{1'b0}};
                end else begin
                    tx_shift_nxt_s = tx_shift_r;
                end
            end
            ST_ACTIVE: begin
                if (sclk_fall_s) begin
                    if (tx_cnt_inc_s == CNT_LAST) begin
                        tx_shift_nxt_s = bus.tx_data;
                        tx_cnt_nxt_s   = {CW{1'b0}};
                    end else begin
                        tx_shift_nxt_s = {tx_shift_r[WIDTH-2:0], 1'b0};
                        tx_cnt_nxt_s   = tx_cnt_inc_s;
                    end
                end else begin
                    tx_shift_nxt_s = tx_shift_r;
                end
            end
            default: begin
                tx_shift_nxt_s = tx_shift_r;
            end
        endcase
        if (state_nxt_s == ST_ACTIVE) begin
            miso_nxt_s = tx_shift_nxt_s[WIDTH-1];
        end else begin
            miso_nxt_s = 1'b0;
        end
    end

    // MISO shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_shift_r <= {WIDTH{1'b0}};
            tx_cnt_r   <= {CW{1'b0}};
        end else begin
            tx_shift_r <= tx_shift_nxt_s;
            tx_cnt_r   <= tx_cnt_nxt_s;
        end
    end
`else
    logic unused_tx_s;
    assign unused_tx_s = ^bus.tx_data ^ sclk_fall_s;
    assign miso_nxt_s  = 1'b0;
`endif

    // Receive datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_r    <= {WIDTH{1'b0}};
            cnt_r      <= {CW{1'b0}};
            rx_data_r  <= {WIDTH{1'b0}};
            rx_valid_r <= 1'b0;
            rx_err_r   <= 1'b0;
            busy_r     <= 1'b0;
            miso_r     <= 1'b0;
        end else begin
            shift_r    <= shift_nxt_s;
            cnt_r      <= cnt_nxt_s;
            rx_data_r  <= rx_data_nxt_s;
            rx_valid_r <= rx_valid_nxt_s;
            rx_err_r   <= rx_err_nxt_s;
            busy_r     <= (state_nxt_s == ST_ACTIVE);
            miso_r     <= miso_nxt_s;
        end
    end

    assign bus.rx_data  = rx_data_r;
    assign bus.rx_valid = rx_valid_r;
    assign bus.rx_err   = rx_err_r;
    assign bus.busy     = busy_r;
    assign bus.miso     = miso_r;

endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx: directed bench for spi_slave_rx. Expected word/error
// events are queued when the stimulus is driven and popped when the DUT
// strobes rx_valid or rx_err. Inputs change on the falling clk edge and
// outputs are sampled there too.
`timescale 1ns/1ps

module tb_spi_slave_rx;

    typedef struct {
        logic        err;
        logic [15:0] data;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   cyc_n;
    int   last_rise_cyc;
    int   last_valid_cyc;
    bit   busy_chk;
    logic [15:0] cur_data;
    exp_t exp_q[$];

    spi_slave_rx_if #(.WIDTH(16)) bus ();

    spi_slave_rx #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance one clk cycle, then score any strobe against the queue.
    task automatic step();
        exp_t e;
        @(negedge clk);
        cyc_n++;
        if (busy_chk) check1("busy_hold", bus.busy, 1'b1);
        if (bus.rx_valid === 1'b1 || bus.rx_err === 1'b1) begin
            if (exp_q.size() == 0) begin
                check16("unexpected_evt", {14'd0, bus.rx_err, bus.rx_valid}, 16'd0);
            end else begin
                e = exp_q.pop_front();
                check16("evt_kind", {14'd0, bus.rx_err, bus.rx_valid}, {14'd0, e.err, ~e.err});
                check16("evt_data", bus.rx_data, e.data);
                if (!e.err) last_valid_cyc = cyc_n;
            end
        end
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic send_bit(input logic b, input int half, input logic m);
        bus.mosi = b;
        steps(half);
        check1("miso_bit", bus.miso, m);
        last_rise_cyc = cyc_n;
        bus.sclk_in = 1'b1;
        steps(half);
        bus.sclk_in = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w, input int half,
                             input logic [15:0] m, input bit expect_word);
        exp_t e;
        if (expect_word) begin
            e.err = 1'b0;
            e.data = w;
            exp_q.push_back(e);
            cur_data = w;
        end
        for (int i = 15; i >= 0; i--) send_bit(w[i], half, m[i]);
    endtask

    task automatic select();
        bus.ss_in = 1'b0;
        steps(4);
    endtask

    task automatic deselect();
        bus.ss_in = 1'b1;
        steps(6);
    endtask

    initial begin
        logic [15:0] tx_exp;
        exp_t e;
        int c0;
        total = 0; bad = 0; cyc_n = 0; busy_chk = 0;
        last_rise_cyc = 0; last_valid_cyc = -100;
        cur_data = 16'h0000;
        rst = 1'b1;
        bus.sclk_in = 1'b0; bus.ss_in = 1'b1; bus.mosi = 1'b0; bus.tx_data = 16'h0000;

        // Reset values
        steps(4);
        check16("rst_rx_data", bus.rx_data, 16'h0000);
        check1("rst_rx_valid", bus.rx_valid, 1'b0);
        check1("rst_rx_err", bus.rx_err, 1'b0);
        check1("rst_busy", bus.busy, 1'b0);
        check1("rst_miso", bus.miso, 1'b0);
        rst = 1'b0;
        steps(6);

        // Reset mid-frame, then traffic in the same frame must be ignored
        select();
        for (int i = 0; i < 5; i++) send_bit(1'b1, 2, 1'b0);
        rst = 1'b1;
        steps(2);
        rst = 1'b0;
        step();
        check1("midrst_busy", bus.busy, 1'b0);
        send_word(16'hFFFF, 2, 16'h0000, 1'b0);
        steps(4);
        check16("ignored_frame_data", bus.rx_data, 16'h0000);
        deselect();
        select();
        send_word(16'hA5C3, 2, 16'h0000, 1'b1);
        steps(4);
        deselect();
        check16("after_rst_word", bus.rx_data, 16'hA5C3);

        // Single word at clk/4 with latency and busy timing
        bus.ss_in = 1'b0;
        c0 = cyc_n;
        steps(2);
        check1("busy_rise_early", bus.busy, 1'b0);
        step();
        check16("busy_rise_lat", 16'(cyc_n - c0), 16'd3);
        check1("busy_rise", bus.busy, 1'b1);
        step();
        last_valid_cyc = -100;
        send_word(16'h1234, 2, 16'h0000, 1'b1);
        steps(4);
        check16("valid_latency", 16'(last_valid_cyc - last_rise_cyc), 16'd3);
        steps(10);
        check16("hold_data", bus.rx_data, 16'h1234);
        bus.ss_in = 1'b1;
        steps(2);
        check1("busy_fall_early", bus.busy, 1'b1);
        step();
        check1("busy_fall", bus.busy, 1'b0);
        steps(4);

        // Two words in one frame, busy held throughout
        select();
        busy_chk = 1;
        send_word(16'hBEEF, 3, 16'h0000, 1'b1);
        send_word(16'h0001, 3, 16'h0000, 1'b1);
        steps(4);
        busy_chk = 0;
        deselect();
        check16("two_words_last", bus.rx_data, 16'h0001);

        // Aborted frame after 7 bits
        select();
        for (int i = 0; i < 7; i++) send_bit(i[0], 2, 1'b0);
        e.err = 1'b1;
        e.data = cur_data;
        exp_q.push_back(e);
        deselect();
        check16("abort_keeps_data", bus.rx_data, 16'h0001);
        select();
        send_word(16'h5555, 2, 16'h0000, 1'b1);
        steps(4);
        deselect();

        // Last SCLK rise and SS rise together
        select();
        e.err = 1'b0;
        e.data = 16'h8001;
        exp_q.push_back(e);
        cur_data = 16'h8001;
        for (int i = 15; i >= 1; i--) send_bit(e.data[i], 2, 1'b0);
        bus.mosi = 1'b1;
        steps(2);
        check1("miso_bit", bus.miso, 1'b0);
        bus.sclk_in = 1'b1;
        bus.ss_in = 1'b1;
        steps(2);
        bus.sclk_in = 1'b0;
        steps(6);
        check16("simul_word", bus.rx_data, 16'h8001);

        // MISO return path
`ifdef SPI_SLAVE_TX_EN
        tx_exp = 16'hC0DE;
`else
        tx_exp = 16'h0000;
`endif
        bus.tx_data = 16'hC0DE;
        select();
        bus.tx_data = 16'h0000;
        send_word(16'h3C96, 4, tx_exp, 1'b1);
        steps(4);
        deselect();
        check1("miso_after_desel", bus.miso, 1'b0);
        check16("tx_frame_word", bus.rx_data, 16'h3C96);

        steps(4);
        check16("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
